// File: rtl/nota_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nota_scheduler
// Purpose  : Queues note requests from a push-button source and a UART source
//            and plays them one at a time on nota_out.
//            Each note is held for DUR_CYCLES clocks. Optionally, a silent gap
//            of GAP_CYCLES clocks follows each note.
//            Optional feature: define NOTA_SCHED_GAP_EN to enable the GAP state.
//            Without it, queued notes play back-to-back and GAP_CYCLES is ignored.
// Ports    : clk        - single clock, rising edge
//            clr        - asynchronous active-high reset
//            btn_valid  - push-button request pulse, note code on btn_nota[2:0]
//            uart_valid - UART request pulse, note code on uart_nota[2:0]
//            flush      - synchronous clear of the queue and of playback
//            nota_out   - note driven to the tone generator (0 = silence)
//            playing    - high while a note is being held
//            count      - number of queued entries (0..DEPTH)
//            drop       - one-cycle pulse, set when a request was discarded
// Revision : 1.0 - initial release
// ============================================================================
module nota_scheduler #(
   parameter int DUR_CYCLES = 12500000,
   parameter int GAP_CYCLES = 1250000,
   parameter int DEPTH      = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       btn_valid,
   input  logic [2:0] btn_nota,
   input  logic       uart_valid,
   input  logic [2:0] uart_nota,
   input  logic       flush,
   output logic [2:0] nota_out,
   output logic       playing,
   output logic [4:0] count,
   output logic       drop
);

   localparam int          c_aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0]  c_depth    = 5'(DEPTH);
   localparam logic [23:0] c_dur_load = 24'(DUR_CYCLES - 1);

   localparam logic [1:0]  c_idle = 2'd0;
   localparam logic [1:0]  c_play = 2'd1;
`ifdef NOTA_SCHED_GAP_EN
   localparam logic [1:0]  c_gap      = 2'd2;
   localparam logic [23:0] c_gap_load = 24'(GAP_CYCLES - 1);
`else
   // The gap length has no effect in the back-to-back build.
   logic [23:0] w_unused_gap;
   assign w_unused_gap = 24'(GAP_CYCLES);
`endif

   logic [2:0]      r_mem [DEPTH];
   logic [c_aw-1:0] r_wptr;
   logic [c_aw-1:0] r_rptr;
   logic [1:0]      r_state;
   logic [23:0]     r_cnt;

   logic [4:0]      w_free;
   logic            w_acc_btn;
   logic            w_acc_uart;
   logic            w_drop;
   logic            w_pop;
   logic [4:0]      w_push_n;
   logic [c_aw-1:0] w_uart_ptr;
   logic            w_note_done;

   // Room is judged on the count at the start of the cycle. A pop in the
   // same cycle does not free space. When both sources request, btn goes first.
   always_comb begin
      w_free      = c_depth - count;
      w_acc_btn   = btn_valid && (w_free != 5'd0);
      w_acc_uart  = uart_valid && (btn_valid ? (w_free >= 5'd2) : (w_free != 5'd0));
      w_drop      = (btn_valid && !w_acc_btn) || (uart_valid && !w_acc_uart);
      w_push_n    = {4'd0, w_acc_btn} + {4'd0, w_acc_uart};
      w_uart_ptr  = w_acc_btn ? r_wptr + c_aw'(1) : r_wptr;
      w_note_done = (r_cnt == 24'd0);
   end

   // A pop always coincides with loading the head note into nota_out.
   always_comb begin
      w_pop = 1'b0;
      case (r_state)
         c_idle:  w_pop = (count != 5'd0);
`ifdef NOTA_SCHED_GAP_EN
         c_gap:   w_pop = w_note_done && (count != 5'd0);
`else
         c_play:  w_pop = w_note_done && (count != 5'd0);
`endif
         default: w_pop = 1'b0;
      endcase
   end

   // The storage array needs no reset. Entries are only read through the
   // pointers and the count, and both of those are reset.
   always_ff @(posedge clk) begin
      if (w_acc_btn)
         r_mem[r_wptr] <= btn_nota;
      if (w_acc_uart)
         r_mem[w_uart_ptr] <= uart_nota;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         count    <= 5'd0;
         r_state  <= c_idle;
         r_cnt    <= 24'd0;
         nota_out <= 3'd0;
         playing  <= 1'b0;
         drop     <= 1'b0;
      end else if (flush) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         count    <= 5'd0;
         r_state  <= c_idle;
         r_cnt    <= 24'd0;
         nota_out <= 3'd0;
         playing  <= 1'b0;
         drop     <= 1'b0;
      end else begin
         r_wptr <= r_wptr + c_aw'(w_push_n);
         count  <= count + w_push_n - {4'd0, w_pop};
         drop   <= w_drop;
         if (w_pop)
            r_rptr <= r_rptr + c_aw'(1);

         if (w_pop) begin
            r_state  <= c_play;
            nota_out <= r_mem[r_rptr];
            playing  <= 1'b1;
            r_cnt    <= c_dur_load;
         end else begin
            case (r_state)
               c_play: begin
                  if (!w_note_done) begin
                     r_cnt <= r_cnt - 24'd1;
                  end else begin
`ifdef NOTA_SCHED_GAP_EN
                     r_state  <= c_gap;
                     r_cnt    <= c_gap_load;
`else
                     r_state  <= c_idle;
`endif
                     nota_out <= 3'd0;
                     playing  <= 1'b0;
                  end
               end
`ifdef NOTA_SCHED_GAP_EN
               c_gap: begin
                  if (!w_note_done) begin
                     r_cnt <= r_cnt - 24'd1;
                  end else begin
                     r_state  <= c_idle;
                     nota_out <= 3'd0;
                     playing  <= 1'b0;
                  end
               end
`endif
               c_idle:  r_state <= c_idle;
               default: r_state <= c_idle;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/nota_scheduler.md
NOTA_SCHEDULER -- requirements
Module: nota_scheduler

Interface
- REQ-001 SHALL have parameter DUR_CYCLES, default 12500000: clocks each note is held on nota_out (range 1..2^24-1).
- REQ-002 SHALL have parameter GAP_CYCLES, default 1250000: silent clocks between notes (range 1..2^24-1).
- REQ-003 SHALL have parameter DEPTH, default 4: note queue depth (power of two, 2..16).
- REQ-004 clk  input  1  single clock; all state changes on rising edge.
- REQ-005 clr  input  1  reset, asynchronous, active-high.
- REQ-006 btn_valid  input  1  push-button note request, one-cycle pulse.
- REQ-007 btn_nota  input  3  note code for btn_valid.
- REQ-008 uart_valid  input  1  UART-decoded note request, one-cycle pulse.
- REQ-009 uart_nota  input  3  note code for uart_valid.
- REQ-010 flush  input  1  synchronous clear of queue and playback.
- REQ-011 nota_out  output  3  note currently driven to tone generator; 0 = silence.
- REQ-012 playing  output  1  high while in PLAY state.
- REQ-013 count  output  5  entries currently queued.
- REQ-014 drop  output  1  one-cycle pulse when any request is discarded for lack of space.

Function
- REQ-015 SHALL queue requests FIFO-ordered; code 0 is queued and played as a rest.
- REQ-016 Acceptance SHALL use count at start of cycle; a pop in the same cycle SHALL NOT create room.
- REQ-017 Both valids, >=2 free: both accepted, btn entry ahead of uart entry.
- REQ-018 Both valids, exactly 1 free: btn accepted, uart discarded, drop=1 next cycle.
- REQ-019 One valid, 0 free: request discarded, drop=1 next cycle.
- REQ-020 States: IDLE, PLAY, GAP; nota_out and playing registered.
- REQ-021 IDLE, count>0: next edge -> PLAY, nota_out=head, pop, duration counter=DUR_CYCLES-1.
- REQ-022 Latency: request in cycle 0 into empty idle scheduler SHALL appear on nota_out in cycle 2.
- REQ-023 PLAY: counter decrements each clock; nota_out held exactly DUR_CYCLES clocks.
- REQ-024 PLAY, counter=0: -> GAP (counter=GAP_CYCLES-1, nota_out=0) when gap enabled; else see REQ-033.
- REQ-025 GAP, counter=0: count>0 -> PLAY with next note (as REQ-021); count=0 -> IDLE, nota_out=0.
- REQ-026 flush SHALL, on next edge, set count=0, state IDLE, nota_out=0, playing=0; requests in the flush cycle discarded without drop.
- REQ-027 count SHALL never exceed DEPTH; read/write pointers wrap modulo DEPTH.
- REQ-028 Requests arriving during PLAY/GAP SHALL be queued without disturbing the current note.

Reset
- REQ-029 clr=1 SHALL immediately force state IDLE, count=0, pointers=0, counter=0, nota_out=0, playing=0, drop=0.
- REQ-030 clr asserted mid-note SHALL abandon the note and queue; no request is accepted while clr=1.
- REQ-031 First activity after clr release SHALL be governed by REQ-021 only.

Configuration
- REQ-032 Macro NOTA_SCHED_GAP_EN defined: GAP state present per REQ-024/REQ-025.
- REQ-033 NOTA_SCHED_GAP_EN undefined: no GAP state, GAP_CYCLES ignored; PLAY, counter=0: count>0 -> reload PLAY with next note same edge (back-to-back), count=0 -> IDLE, nota_out=0.

Verification (DUR_CYCLES=4, GAP_CYCLES=2, DEPTH=4, macro defined unless stated)
- REQ-034 btn_valid, btn_nota=5 in cycle 0 -> nota_out=5, playing=1 cycles 2-5; nota_out=0 cycles 6-7; IDLE from cycle 8.
- REQ-035 btn 3 and uart 6 same cycle, queue empty -> count=2; plays 3 then 6 with 2-clock gap between.
- REQ-036 Fill queue to 4, then btn+uart pulse -> both discarded, drop=1 one cycle, count stays 4.
- REQ-037 flush during PLAY of note 2 with 2 queued -> next cycle nota_out=0, count=0, IDLE; no further notes.
- REQ-038 clr pulse mid-PLAY -> outputs zero asynchronously before next edge; new request afterwards obeys 2-cycle latency.
- REQ-039 Macro undefined, notes 1,2 queued -> nota_out 1 for 4 clocks then 2 for 4 clocks with no zero cycle between.
